// File: rtl/telemetry_framer_pkg.sv
// Shared constants, FSM encoding and helpers for the telemetry framer.
// ASCII bytes, state names and frame-length/digit-count helpers.
package telemetry_pkg;

    localparam logic [7:0] TAG_BASE = 8'h41;
    localparam logic [7:0] SEP      = 8'h2C;
    localparam logic [7:0] CR       = 8'h0D;
    localparam logic [7:0] LF       = 8'h0A;
    localparam logic [7:0] ZERO     = 8'h30;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LATCH,
        S_CONV,
        S_TAG,
        S_DIG,
        S_SEP,
        S_CR,
        S_LF,
        S_DONE
    } state_t;

    function automatic int frame_len(input int num_ch, input int digits);
        return num_ch * (digits + 1) + (num_ch - 1) + 2;
    endfunction

    // True when DIGITS decimal digits can hold the largest DATA_W-bit value.
    function automatic bit digits_fit(input int data_w, input int digits);
        longint unsigned maxv;
        longint unsigned p;
        maxv = (longint'(1) << data_w) - 1;
        p    = 1;
        for (int i = 0; i < digits; i++) begin
            p = p * 10;
            if (p > maxv) return 1'b1;
        end
        return (p > maxv);
    endfunction

endpackage

// File: rtl/telemetry_framer_if.sv
// Byte stream from the framer to the UART transmitter.
// A byte moves on a cycle with tx_data_valid && tx_ready; while valid is high and
// not accepted, tx_data_in holds steady; ready with valid low does nothing.
interface telemetry_framer_if;
    logic       tx_data_valid;
    logic [7:0] tx_data_in;
    logic       tx_ready;

    modport master (output tx_data_valid, output tx_data_in, input tx_ready);
    modport slave  (input tx_data_valid, input tx_data_in, output tx_ready);
endinterface

// File: rtl/telemetry_framer_bin2bcd_seq.sv
// Sequential double-dabble: one bit shifted in per cycle after a start load.
// done is high during the final shift cycle; bcd is final on the following cycle.
module bin2bcd_seq #(
    parameter int DATA_W = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_W-1:0]     bin,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0]   sh;
    logic [CNT_W-1:0]    cnt;
    logic                running;
    logic [4*DIGITS-1:0] adj;

    always_comb begin
        adj = bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
        end
    end

    assign done = running && (cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh      <= '0;
            bcd     <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            sh      <= bin;
            bcd     <= '0;
            cnt     <= CNT_W'(DATA_W);
            running <= 1'b1;
        end else if (running) begin
            bcd <= {adj[4*DIGITS-2:0], sh[DATA_W-1]};
            sh  <= sh << 1;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) running <= 1'b0;
        end
    end

endmodule

// File: rtl/telemetry_framer.sv
// Multi-channel telemetry framer: snapshot N words, convert to decimal ASCII and
// stream "A<d>,B<d>,...\r\n" to the UART with periodic trigger and overrun count.
module telemetry_framer
    import telemetry_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 16,
    parameter int DIGITS     = 5,
    parameter int PERIOD_CYC = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic                     trans_en,
    telemetry_framer_if.master       tx,
    output logic                     busy,
    output logic                     frame_done,
    output logic [7:0]               drop_cnt,
    output state_t                   state
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [DIG_W-1:0] LAST_DIG = DIG_W'(DIGITS - 1);
    localparam logic [31:0]      PLAST    = (PERIOD_CYC > 0) ? 32'(PERIOD_CYC - 1) : 32'd0;

    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
        $error("telemetry_framer: NUM_CH must be 1..8");
    end
    if (!digits_fit(DATA_W, DIGITS)) begin : g_bad_digits
        $error("telemetry_framer: DIGITS too small for DATA_W");
    end

    state_t                   state_next;
    logic [NUM_CH*DATA_W-1:0] snap;
    logic [CH_W-1:0]          ch;
    logic [DIG_W-1:0]         dig;
    logic                     pending;
    logic                     conv_started;
    logic                     conv_start;
    logic                     conv_done;
    logic [31:0]              pcnt;
    logic                     period_hit;
    logic                     req;
    logic                     accept;
    logic [DATA_W-1:0]        cur_word;
    logic [4*DIGITS-1:0]      bcd;
    logic [3:0]               cur_digit;

    assign period_hit = (PERIOD_CYC > 0) && (pcnt == PLAST);
    assign req        = trans_en || period_hit;
    assign accept     = tx.tx_data_valid && tx.tx_ready;
    assign busy       = (state != S_IDLE);
    assign frame_done = (state == S_DONE);

    always_comb begin
        cur_word = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch == CH_W'(k)) cur_word = snap[k*DATA_W +: DATA_W];
        end
        cur_digit = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (dig == DIG_W'(d)) cur_digit = bcd[4*(DIGITS-1-d) +: 4];
        end
    end

    bin2bcd_seq #(.DATA_W(DATA_W), .DIGITS(DIGITS)) u_bcd (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .bin   (cur_word),
        .done  (conv_done),
        .bcd   (bcd)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next       = state;
        conv_start       = 1'b0;
        tx.tx_data_valid = 1'b0;
        tx.tx_data_in    = 8'h00;
        unique case (state)
            S_IDLE:  if (req || pending) state_next = S_LATCH;
            S_LATCH: state_next = S_CONV;
            S_CONV: begin
                conv_start = !conv_started;
                if (conv_done) state_next = S_TAG;
            end
            S_TAG: begin
                tx.tx_data_valid = 1'b1;
                tx.tx_data_in    = TAG_BASE + 8'(ch);
                if (tx.tx_ready) state_next = S_DIG;
            end
            S_DIG: begin
                tx.tx_data_valid = 1'b1;
                tx.tx_data_in    = ZERO + {4'h0, cur_digit};
                if (tx.tx_ready && dig == LAST_DIG) state_next = (ch == LAST_CH) ? S_CR : S_SEP;
            end
            S_SEP: begin
                tx.tx_data_valid = 1'b1;
                tx.tx_data_in    = SEP;
                if (tx.tx_ready) state_next = S_CONV;
            end
            S_CR: begin
                tx.tx_data_valid = 1'b1;
                tx.tx_data_in    = CR;
                if (tx.tx_ready) state_next = S_LF;
            end
            S_LF: begin
                tx.tx_data_valid = 1'b1;
                tx.tx_data_in    = LF;
                if (tx.tx_ready) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Period counter free-runs regardless of busy so triggers stay on a fixed grid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap         <= '0;
            ch           <= '0;
            dig          <= '0;
            pending      <= 1'b0;
            drop_cnt     <= '0;
            pcnt         <= '0;
            conv_started <= 1'b0;
        end else begin
            conv_started <= (state == S_CONV) && (state_next == S_CONV);
            if (PERIOD_CYC > 0) pcnt <= period_hit ? 32'd0 : pcnt + 32'd1;
            if (state == S_IDLE) begin
                pending <= 1'b0;
            end else if (req) begin
                pending <= 1'b1;
                if (pending && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end
            case (state)
                S_LATCH: begin
                    snap <= ch_data;
                    ch   <= '0;
                end
                S_TAG:   if (accept) dig <= '0;
                S_DIG:   if (accept) dig <= dig + DIG_W'(1);
                S_SEP:   if (accept) ch  <= ch + CH_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_telemetry_framer.sv
// Directed bench for telemetry_framer: a default two-channel instance and a
// four-channel 8-bit instance with the periodic trigger enabled.
module tb_telemetry_framer;
    import telemetry_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        reset1 = 1'b0;
    logic [31:0] ch_data1 = '0;
    logic        trans_en1 = 1'b0;
    logic        busy1, frame_done1;
    logic [7:0]  drop1;
    state_t      state1;
    telemetry_framer_if if1();

    logic        reset2 = 1'b0;
    logic [31:0] ch_data2 = {8'd255, 8'd99, 8'd42, 8'd7};
    logic        trans_en2 = 1'b0;
    logic        busy2, frame_done2;
    logic [7:0]  drop2;
    state_t      state2;
    telemetry_framer_if if2();

    telemetry_framer dut1 (
        .clk(clk), .reset(reset1), .ch_data(ch_data1), .trans_en(trans_en1), .tx(if1),
        .busy(busy1), .frame_done(frame_done1), .drop_cnt(drop1), .state(state1)
    );

    telemetry_framer #(.NUM_CH(4), .DATA_W(8), .DIGITS(3), .PERIOD_CYC(200)) dut2 (
        .clk(clk), .reset(reset2), .ch_data(ch_data2), .trans_en(trans_en2), .tx(if2),
        .busy(busy2), .frame_done(frame_done2), .drop_cnt(drop2), .state(state2)
    );

    logic [7:0] exp_q[$];
    logic [7:0] got1_q[$];
    logic [7:0] got2_q[$];
    int         done2_cyc[$];
    int         done1 = 0;
    int         unstable1 = 0;
    bit         hold1 = 1'b0;
    logic [7:0] held1 = '0;

    // Byte collection, frame_done counting and hold-stability tracking.
    always @(negedge clk) begin
        if (if1.tx_data_valid && if1.tx_ready) got1_q.push_back(if1.tx_data_in);
        if (hold1 && (!if1.tx_data_valid || if1.tx_data_in !== held1)) unstable1++;
        hold1 = if1.tx_data_valid && !if1.tx_ready;
        held1 = if1.tx_data_in;
        if (frame_done1) done1++;
        if (if2.tx_data_valid && if2.tx_ready) got2_q.push_back(if2.tx_data_in);
        if (frame_done2) done2_cyc.push_back(cyc);
    end

    task automatic add_frame(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Pulses trans_en, then runs until want_done frames finish or the budget expires.
    task automatic run1(input int rdy_pct, input int extra_pulses, input bit mid_change,
                        input int want_done, output int lat, output bit busy_n1, output bit timeout);
        int n;
        got1_q.delete();
        done1   = 0;
        lat     = -1;
        busy_n1 = 1'b0;
        timeout = 1'b0;
        @(posedge clk); #1;
        trans_en1   = 1'b1;
        if1.tx_ready = ($urandom_range(1, 100) <= rdy_pct);
        n = 0;
        while (done1 < want_done) begin
            @(posedge clk); #1;
            n++;
            trans_en1 = (extra_pulses > 0) && (n % 5 == 0) && (n / 5 <= extra_pulses);
            if (mid_change && n == 30) ch_data1 = ~ch_data1;
            if1.tx_ready = ($urandom_range(1, 100) <= rdy_pct);
            if (n == 1) busy_n1 = busy1;
            if (lat < 0 && if1.tx_data_valid) lat = n;
            if (n > 3000) begin
                timeout = 1'b1;
                break;
            end
        end
        trans_en1    = 1'b0;
        if1.tx_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #3;
        checks++; if (if1.tx_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", if1.tx_data_valid); end
        checks++; if (if1.tx_data_in !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", if1.tx_data_in); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy1); end
        checks++; if (frame_done1 !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", frame_done1); end
        checks++; if (drop1 !== 8'h00) begin errors++; $display("FAIL reset_drop got %0d exp 0", drop1); end
        checks++; if (state1 !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d exp IDLE", state1); end
        @(posedge clk); #1;
        reset1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        int lat; bit b1; bit to;
        ch_data1 = {16'd612, 16'd253};
        exp_q.delete();
        add_frame("A00253,B00612");
        run1(100, 0, 1'b0, 1, lat, b1, to);
        checks++; if (to) begin errors++; $display("FAIL basic_timeout got timeout exp frame_done"); end
        checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL basic_busy_t1 got %b exp 1", b1); end
        checks++; if (lat != 19) begin errors++; $display("FAIL basic_latency got %0d exp 19", lat); end
        checks++; if (got1_q.size() != 15) begin errors++; $display("FAIL basic_len got %0d exp 15", got1_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got1_q.size(); i++) begin
            checks++;
            if (got1_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_byte%0d got %h exp %h", i, got1_q[i], exp_q[i]); end
        end
        checks++; if (done1 != 1) begin errors++; $display("FAIL basic_done_pulses got %0d exp 1", done1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b exp 0", busy1); end
    endtask

    task automatic test_extremes;
        int lat; bit b1; bit to;
        ch_data1 = {16'd0, 16'd65535};
        exp_q.delete();
        add_frame("A65535,B00000");
        run1(100, 0, 1'b1, 1, lat, b1, to);
        checks++; if (to) begin errors++; $display("FAIL extreme_timeout got timeout exp frame_done"); end
        checks++; if (got1_q.size() != exp_q.size()) begin errors++; $display("FAIL extreme_len got %0d exp %0d", got1_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got1_q.size(); i++) begin
            checks++;
            if (got1_q[i] !== exp_q[i]) begin errors++; $display("FAIL extreme_byte%0d got %h exp %h", i, got1_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure;
        int lat; bit b1; bit to;
        ch_data1  = {16'd612, 16'd253};
        unstable1 = 0;
        exp_q.delete();
        add_frame("A00253,B00612");
        run1(30, 0, 1'b0, 1, lat, b1, to);
        checks++; if (to) begin errors++; $display("FAIL bp_timeout got timeout exp frame_done"); end
        checks++; if (got1_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_len got %0d exp %0d", got1_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got1_q.size(); i++) begin
            checks++;
            if (got1_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_byte%0d got %h exp %h", i, got1_q[i], exp_q[i]); end
        end
        checks++; if (unstable1 != 0) begin errors++; $display("FAIL bp_hold_stable got %0d changes exp 0", unstable1); end
        checks++; if (done1 != 1) begin errors++; $display("FAIL bp_done_pulses got %0d exp 1", done1); end
    endtask

    task automatic test_overrun;
        int lat; bit b1; bit to;
        ch_data1 = {16'd40000, 16'd1};
        exp_q.delete();
        add_frame("A00001,B40000");
        add_frame("A00001,B40000");
        run1(100, 3, 1'b0, 2, lat, b1, to);
        repeat (60) @(posedge clk);
        #1;
        checks++; if (to) begin errors++; $display("FAIL overrun_timeout got timeout exp 2 frames"); end
        checks++; if (done1 != 2) begin errors++; $display("FAIL overrun_frames got %0d exp 2", done1); end
        checks++; if (drop1 !== 8'd2) begin errors++; $display("FAIL overrun_drop got %0d exp 2", drop1); end
        checks++; if (got1_q.size() != 30) begin errors++; $display("FAIL overrun_len got %0d exp 30", got1_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got1_q.size(); i++) begin
            checks++;
            if (got1_q[i] !== exp_q[i]) begin errors++; $display("FAIL overrun_byte%0d got %h exp %h", i, got1_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid;
        int n; int lat; bit b1; bit to;
        ch_data1 = {16'd54321, 16'd12345};
        @(posedge clk); #1;
        trans_en1 = 1'b1;
        @(posedge clk); #1;
        trans_en1 = 1'b0;
        n = 0;
        while (state1 != S_DIG && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (state1 !== S_DIG) begin errors++; $display("FAIL midrst_reach_dig got %0d exp DIG", state1); end
        #2 reset1 = 1'b0;
        #1;
        checks++; if (if1.tx_data_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", if1.tx_data_valid); end
        checks++; if (if1.tx_data_in !== 8'h00) begin errors++; $display("FAIL midrst_data got %h exp 00", if1.tx_data_in); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy1); end
        checks++; if (drop1 !== 8'h00) begin errors++; $display("FAIL midrst_drop got %0d exp 0", drop1); end
        checks++; if (frame_done1 !== 1'b0) begin errors++; $display("FAIL midrst_done got %b exp 0", frame_done1); end
        repeat (3) @(posedge clk);
        #1 reset1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        ch_data1 = {16'd9, 16'd42};
        exp_q.delete();
        add_frame("A00042,B00009");
        run1(100, 0, 1'b0, 1, lat, b1, to);
        checks++; if (to) begin errors++; $display("FAIL midrst_timeout got timeout exp frame_done"); end
        checks++; if (got1_q.size() != exp_q.size()) begin errors++; $display("FAIL midrst_len got %0d exp %0d", got1_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got1_q.size(); i++) begin
            checks++;
            if (got1_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_byte%0d got %h exp %h", i, got1_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_period;
        exp_q.delete();
        add_frame("A007,B042,C099,D255");
        add_frame("A007,B042,C099,D255");
        got2_q.delete();
        done2_cyc.delete();
        if2.tx_ready = 1'b1;
        @(posedge clk); #1;
        reset2 = 1'b1;
        repeat (520) @(posedge clk);
        #1;
        checks++; if (done2_cyc.size() != 2) begin errors++; $display("FAIL period_frames got %0d exp 2", done2_cyc.size()); end
        if (done2_cyc.size() >= 2) begin
            checks++;
            if (done2_cyc[1] - done2_cyc[0] != 200) begin errors++; $display("FAIL period_interval got %0d exp 200", done2_cyc[1] - done2_cyc[0]); end
        end
        checks++; if (got2_q.size() != 42) begin errors++; $display("FAIL period_len got %0d exp 42", got2_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got2_q.size(); i++) begin
            checks++;
            if (got2_q[i] !== exp_q[i]) begin errors++; $display("FAIL period_byte%0d got %h exp %h", i, got2_q[i], exp_q[i]); end
        end
        checks++; if (drop2 !== 8'h00) begin errors++; $display("FAIL period_drop got %0d exp 0", drop2); end
    endtask

    initial begin
        if1.tx_ready = 1'b1;
        if2.tx_ready = 1'b1;
        test_reset();
        test_basic();
        test_extremes();
        test_backpressure();
        test_overrun();
        test_reset_mid();
        test_period();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
